// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit for the EX stage: multi-cycle MULT/DIV/MADD/MSUB,
// architectural HI/LO registers, MTHI/MTLO writes, MFHI/MFLO reads and the stall request.
module mul_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_en,
  input  logic [3:0]  mul_op,
  input  logic [1:0]  mthilo,
  input  logic [1:0]  mfhilo,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hilo_rd
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [63:0]   pend;
  logic [CW-1:0] cnt;

  logic          op_valid;
  logic          mt_valid;
  logic          mf_valid;
  logic          uses_md;
  logic          is_div;

  logic [63:0]   prod_u;
  logic [63:0]   prod_s;
  logic [31:0]   mag_a;
  logic [31:0]   mag_b;
  logic [31:0]   safe_b;
  logic [31:0]   quo_u;
  logic [31:0]   rem_u;
  logic [31:0]   quo_m;
  logic [31:0]   rem_m;
  logic [31:0]   quo_s;
  logic [31:0]   rem_s;
  logic [63:0]   result;

  assign op_valid = ~mul_op[3];
  assign mt_valid = ~mthilo[1];
  assign mf_valid = (mfhilo == 2'b01) || (mfhilo == 2'b10);
  assign uses_md  = issue_en & (op_valid | mt_valid | mf_valid);
  assign is_div   = (mul_op[2:1] == 2'b01);

  assign busy     = (cnt != '0);
  assign start    = issue_en & op_valid & ~busy;
  assign md_stall = uses_md & busy;

  always_comb begin
    hilo_rd = 32'h0;
    if (!md_stall) begin
      if (mfhilo == 2'b10)      hilo_rd = hi;
      else if (mfhilo == 2'b01) hilo_rd = lo;
    end
  end

  // Signed results come from sign-extending to 64 bits (multiply) or from
  // magnitude division with sign fix-up, which also covers 0x80000000 / -1.
  always_comb begin
    prod_u = {32'h0, op_a} * {32'h0, op_b};
    prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
    mag_a  = op_a[31] ? -op_a : op_a;
    mag_b  = op_b[31] ? -op_b : op_b;
    safe_b = (op_b == 32'h0) ? 32'h1 : op_b;
    quo_u  = op_a / safe_b;
    rem_u  = op_a % safe_b;
    quo_m  = mag_a / ((mag_b == 32'h0) ? 32'h1 : mag_b);
    rem_m  = mag_a % ((mag_b == 32'h0) ? 32'h1 : mag_b);
    quo_s  = (op_a[31] ^ op_b[31]) ? -quo_m : quo_m;
    rem_s  = op_a[31] ? -rem_m : rem_m;
  end

  always_comb begin
    result = {hi, lo};
    case (mul_op[2:0])
      3'd0: result = prod_u;
      3'd1: result = prod_s;
      3'd2: if (op_b != 32'h0) result = {rem_u, quo_u};
      3'd3: if (op_b != 32'h0) result = {rem_s, quo_s};
      3'd4: result = {hi, lo} + prod_u;
      3'd5: result = {hi, lo} + prod_s;
      3'd6: result = {hi, lo} - prod_u;
      3'd7: result = {hi, lo} - prod_s;
      default: result = {hi, lo};
    endcase
  end

  // HI/LO change only at commit or by an MTxx while idle, so a divide-by-zero
  // op simply commits the unchanged value it captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= 32'h0;
      lo   <= 32'h0;
      pend <= 64'h0;
      cnt  <= '0;
    end else if (start) begin
      pend <= result;
      cnt  <= is_div ? DIV_LOAD : MUL_LOAD;
    end else if (busy) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        hi <= pend[63:32];
        lo <= pend[31:0];
      end
    end else if (issue_en && mt_valid) begin
      if (mthilo[0]) hi <= op_a;
      else           lo <= op_a;
    end
  end

endmodule
